// File: rtl/noc_flit_link_sender_pkg.sv
// Shared NoC link parameters and typedefs for the link sender and the downstream flit FIFO.
package noc_flit_link_sender_pkg;

    localparam int Noc_VC_Channel = 2;
    localparam int Noc_Flit_Width = 32;

    typedef logic [Noc_VC_Channel-1:0] noc_link_valid_t;
    typedef logic [Noc_Flit_Width-1:0] noc_link_flit_t;

endpackage

// File: rtl/noc_flit_link_sender_if.sv
// Upstream VC handshake plus physical link signals; master = sender view, slave = environment view.
interface noc_flit_link_sender_if
    import noc_flit_link_sender_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int FLIT_WIDTH = Noc_Flit_Width
) ();

    logic [CHANNELS-1:0]                 i_vc_valid;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_vc_flit;
    logic [CHANNELS-1:0]                 o_vc_ready;
    logic [CHANNELS-1:0]                 o_link_valid;
    logic [FLIT_WIDTH-1:0]               o_link_flit;
    logic [CHANNELS-1:0]                 i_link_ready;
    logic [CHANNELS-1:0]                 i_link_vc_ready;

    modport master (
        input  i_vc_valid, i_vc_flit, i_link_ready, i_link_vc_ready,
        output o_vc_ready, o_link_valid, o_link_flit
    );

    modport slave (
        output i_vc_valid, i_vc_flit, i_link_ready, i_link_vc_ready,
        input  o_vc_ready, o_link_valid, o_link_flit
    );

endinterface

// File: rtl/noc_flit_link_sender_arb.sv
// noc_rr_arbiter: round-robin one-hot grant, search starts after the last granted request.
module noc_rr_arbiter
    import noc_flit_link_sender_pkg::*;
#(
    parameter int N = Noc_VC_Channel
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(last_q) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                last_d     = idx;
            end
        end
        // Disabled: no grant leaves the block and the pointer is frozen.
        if (!en_i) begin
            gnt_o  = '0;
            last_d = last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= PW'(N - 1);
        else     last_q <= last_d;
    end

endmodule

// File: rtl/noc_flit_link_sender.sv
// NoC link transmit end: RR pick among eligible VCs, registered one-hot link valid + flit.
// Optional per-VC saturating send counters under `NOC_LINK_SENDER_STATS_EN.
module noc_flit_link_sender
    import noc_flit_link_sender_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int FLIT_WIDTH = Noc_Flit_Width,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                               noc_clk,
    input  logic                               noc_rst,
    input  logic                               i_clear,
    noc_flit_link_sender_if.master             lnk,
    output logic [CHANNELS-1:0][CNT_WIDTH-1:0] o_flit_count
);

    logic                  rst_any;
    logic [CHANNELS-1:0]   elig, gnt;
    logic [CHANNELS-1:0]   link_valid_q, link_valid_d;
    logic [FLIT_WIDTH-1:0] link_flit_q, link_flit_d;

    assign rst_any = noc_rst | i_clear;
    assign elig    = lnk.i_vc_valid & lnk.i_link_ready & lnk.i_link_vc_ready;

    noc_rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk   (noc_clk),
        .rst   (rst_any),
        .en_i  (~rst_any),
        .req_i (elig),
        .gnt_o (gnt)
    );

    assign lnk.o_vc_ready   = gnt;
    assign lnk.o_link_valid = link_valid_q;
    assign lnk.o_link_flit  = link_flit_q;

    always_comb begin
        link_valid_d = gnt;
        link_flit_d  = link_flit_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gnt[c]) link_flit_d = lnk.i_vc_flit[c];
        end
    end

    // Reset or clear drops whatever flit sits in the output register.
    always_ff @(posedge noc_clk) begin
        if (rst_any) begin
            link_valid_q <= '0;
            link_flit_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_flit_q  <= link_flit_d;
        end
    end

`ifdef NOC_LINK_SENDER_STATS_EN
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q;

    // Clear leaves statistics alone; gnt is already forced to zero while it is high.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            cnt_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (gnt[c] && (cnt_q[c] != {CNT_WIDTH{1'b1}})) cnt_q[c] <= cnt_q[c] + CNT_WIDTH'(1);
            end
        end
    end

    assign o_flit_count = cnt_q;
`else
    assign o_flit_count = '0;
`endif

endmodule

// File: tb/tb_noc_flit_link_sender.sv
// Directed bench for noc_flit_link_sender: CHANNELS=2, FLIT_WIDTH=8, CNT_WIDTH=4.
module tb_noc_flit_link_sender;

    localparam int CH = 2;
    localparam int FW = 8;
    localparam int CW = 4;

    logic                  clk;
    logic                  rst;
    logic                  clr;
    logic [CH-1:0][CW-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int exp0   = 0;
    int exp1   = 0;

    noc_flit_link_sender_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) lif ();

    noc_flit_link_sender #(.CHANNELS(CH), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .noc_clk      (clk),
        .noc_rst      (rst),
        .i_clear      (clr),
        .lnk          (lif),
        .o_flit_count (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt(input int n);
`ifdef NOC_LINK_SENDER_STATS_EN
        return (n > 15) ? 15 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk_cnt(input string tag);
        check({tag, "_cnt0"}, 32'(cnt[0]), 32'(exp_cnt(exp0)));
        check({tag, "_cnt1"}, 32'(cnt[1]), 32'(exp_cnt(exp1)));
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] rdy, input logic [1:0] vrdy);
        lif.i_vc_valid      = v;
        lif.i_link_ready    = rdy;
        lif.i_link_vc_ready = vrdy;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        lif.i_vc_flit[0] = 8'h11;
        lif.i_vc_flit[1] = 8'hA5;
        drive(2'b11, 2'b11, 2'b11);
        tick();
        tick();
        // Reset state; grants forced off while reset is high
        check("rst_vc_ready", 32'(lif.o_vc_ready), 32'h0);
        check("rst_link_valid", 32'(lif.o_link_valid), 32'h0);
        check("rst_link_flit", 32'(lif.o_link_flit), 32'h0);
        chk_cnt("rst");

        // Only VC1 valid
        rst = 1'b0;
        drive(2'b10, 2'b11, 2'b11);
        check("vc1_ready", 32'(lif.o_vc_ready), 32'h2);
        tick();
        exp1++;
        check("vc1_link_valid", 32'(lif.o_link_valid), 32'h2);
        check("vc1_link_flit", 32'(lif.o_link_flit), 32'hA5);
        drive(2'b00, 2'b11, 2'b11);
        check("idle_ready", 32'(lif.o_vc_ready), 32'h0);
        tick();
        check("idle_link_valid", 32'(lif.o_link_valid), 32'h0);
        check("idle_flit_hold", 32'(lif.o_link_flit), 32'hA5);
        chk_cnt("vc1");

        // Fresh reset, then alternation 01,10,01,10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp0 = 0;
        exp1 = 0;
        lif.i_vc_flit[1] = 8'h22;
        drive(2'b11, 2'b11, 2'b11);
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", 32'(lif.o_vc_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check("rr_link_valid", 32'(lif.o_link_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_link_flit", 32'(lif.o_link_flit), (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        exp0 += 2;
        exp1 += 2;
        chk_cnt("rr");

        // VC0 almost full: only VC1, then VC0 first once it recovers
        drive(2'b11, 2'b11, 2'b10);
        for (int k = 0; k < 3; k++) begin
            check("af_ready", 32'(lif.o_vc_ready), 32'h2);
            tick();
            check("af_link_valid", 32'(lif.o_link_valid), 32'h2);
        end
        exp1 += 3;
        drive(2'b11, 2'b11, 2'b11);
        check("af_recover_ready", 32'(lif.o_vc_ready), 32'h1);
        tick();
        exp0++;
        check("af_recover_link", 32'(lif.o_link_valid), 32'h1);

        // VC0 full overrides its vc_ready flag
        drive(2'b11, 2'b10, 2'b11);
        for (int k = 0; k < 3; k++) begin
            check("full_ready", 32'(lif.o_vc_ready), 32'h2);
            tick();
            check("full_link_valid", 32'(lif.o_link_valid), 32'h2);
        end
        exp1 += 3;
        chk_cnt("full");

        // Grant VC0 so the pointer sits at 0, then clear with both valid
        drive(2'b01, 2'b11, 2'b11);
        tick();
        exp0++;
        check("pre_clr_link", 32'(lif.o_link_valid), 32'h1);
        clr = 1'b1;
        drive(2'b11, 2'b11, 2'b11);
        check("clr_ready", 32'(lif.o_vc_ready), 32'h0);
        tick();
        check("clr_link_valid", 32'(lif.o_link_valid), 32'h0);
        check("clr_link_flit", 32'(lif.o_link_flit), 32'h0);
        chk_cnt("clr");
        clr = 1'b0;
        #1;
        check("post_clr_ready", 32'(lif.o_vc_ready), 32'h1);
        tick();
        exp0++;
        check("post_clr_link", 32'(lif.o_link_valid), 32'h1);
        check("post_clr_flit", 32'(lif.o_link_flit), 32'h11);

        // Back-to-back VC0 sends toward counter saturation
        drive(2'b01, 2'b11, 2'b11);
        for (int k = 0; k < 20; k++) tick();
        exp0 += 20;
        check("b2b_link_valid", 32'(lif.o_link_valid), 32'h1);
        chk_cnt("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
